// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Purpose  : Shared types and widths for the register-file writeback arbiter.
//            Holds the RF address/data/tag widths, the grant encoding and
//            the queued-write entry record used by the FIFO and the top.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int POS_W     = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_CGRA = 2'd2
  } grant_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
    logic [POS_W-1:0]     pos;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular FIFO for queued CGRA writeback entries. Exposes the
//            per-slot valid vector and rd array so the top can compare
//            decode-stage source addresses against every queued write.
// Ports    : clk_i, reset (async, active-high)
//            i_push/i_entry  - enqueue one entry (ignored when full)
//            i_pop           - dequeue head (ignored when empty)
//            i_flush         - discard all entries; overrides push/pop
//            o_head          - entry at the read pointer
//            o_count         - registered occupancy
//            o_valid, o_rd   - slot-indexed valid flags and destination regs
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset,
  input  logic                                 i_push,
  input  wb_entry_t                            i_entry,
  input  logic                                 i_pop,
  input  logic                                 i_flush,
  output wb_entry_t                            o_head,
  output logic [$clog2(DEPTH):0]               o_count,
  output logic [DEPTH-1:0]                     o_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]      o_rd
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count < (AW+1)'(DEPTH)) && !i_flush;
  assign w_do_pop  = i_pop  && (r_count != '0) && !i_flush;

  // Payload storage needs no reset: slots are only read when marked valid.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // A slot is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [AW-1:0] w_off;
    assign w_off      = AW'(i) - r_rd_ptr;
    assign o_valid[i] = ({1'b0, w_off} < r_count);
    assign o_rd[i]    = r_mem[i].rd;
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the register file write port between CPU writeback
//            (absolute priority, never stalled) and queued CGRA results.
//            Also flags RAW hazards against queued CGRA writes and raises a
//            starvation request when the queue has been blocked too long.
// Ports    : clk_i, reset (async, active-high)
//            cpu_we_i/rd/data/pos       - CPU writeback
//            cgra_valid_i/ready_o/...   - CGRA result handshake
//            flush_i                    - discard queued CGRA results
//            rs_addr_i, rt_addr_i       - decode sources -> hazard_o
//            starve_o                   - bubble request
//            fifo_count_o               - queue occupancy
//            rf_we_o/rd/data/pos        - registered RF write port
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk_i,
  input  logic                       reset,
  input  logic                       cpu_we_i,
  input  logic [RF_ADDR_W-1:0]       cpu_rd_i,
  input  logic [RF_DATA_W-1:0]       cpu_data_i,
  input  logic [POS_W-1:0]           cpu_pos_i,
  input  logic                       cgra_valid_i,
  output logic                       cgra_ready_o,
  input  logic [RF_ADDR_W-1:0]       cgra_rd_i,
  input  logic [RF_DATA_W-1:0]       cgra_data_i,
  input  logic [POS_W-1:0]           cgra_pos_i,
  input  logic                       flush_i,
  input  logic [RF_ADDR_W-1:0]       rs_addr_i,
  input  logic [RF_ADDR_W-1:0]       rt_addr_i,
  output logic                       hazard_o,
  output logic                       starve_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       rf_we_o,
  output logic [RF_ADDR_W-1:0]       rf_rd_o,
  output logic [RF_DATA_W-1:0]       rf_data_o,
  output logic [POS_W-1:0]           rf_pos_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t                        w_head;
  wb_entry_t                        w_in_entry;
  logic [AW:0]                      w_count;
  logic [DEPTH-1:0]                 w_valid;
  logic [DEPTH-1:0][RF_ADDR_W-1:0]  w_rd;
  logic                             w_empty;
  logic                             w_push;
  logic                             w_pop;
  logic                             w_hazard;
  grant_e                           w_grant;

  logic [SW-1:0]                    r_starve_cnt;
  logic                             r_we;
  wb_entry_t                        r_out;

  assign w_empty      = (w_count == '0);
  assign cgra_ready_o = (w_count < (AW+1)'(DEPTH));
  assign w_in_entry   = '{rd: cgra_rd_i, data: cgra_data_i, pos: cgra_pos_i};

  // x0 results complete the handshake but are never queued.
  assign w_push = cgra_valid_i && cgra_ready_o && (cgra_rd_i != '0);

  always_comb begin
    w_grant = GNT_NONE;
    if (cpu_we_i && (cpu_rd_i != '0))
      w_grant = GNT_CPU;
    else if (!w_empty && !flush_i)
      w_grant = GNT_CGRA;
  end

  assign w_pop = (w_grant == GNT_CGRA);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .i_push  (w_push),
    .i_entry (w_in_entry),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .o_head  (w_head),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_rd    (w_rd)
  );

  // Output register: on an idle cycle only the strobe drops; address,
  // data and tag keep their last value.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_we  <= 1'b0;
      r_out <= '0;
    end else begin
      case (w_grant)
        GNT_CPU: begin
          r_we  <= 1'b1;
          r_out <= '{rd: cpu_rd_i, data: cpu_data_i, pos: cpu_pos_i};
        end
        GNT_CGRA: begin
          r_we  <= 1'b1;
          r_out <= w_head;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  // Counts CPU-won cycles that left a non-empty queue waiting.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (flush_i || w_pop || w_empty) begin
      r_starve_cnt <= '0;
    end else if ((w_grant == GNT_CPU) && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  // Head entry still counts while being popped: its write is not yet
  // visible in the register file this cycle.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] &&
          (((rs_addr_i != '0) && (w_rd[i] == rs_addr_i)) ||
           ((rt_addr_i != '0) && (w_rd[i] == rt_addr_i))))
        w_hazard = 1'b1;
    end
  end

  assign hazard_o     = w_hazard;
  assign starve_o     = (r_starve_cnt == SW'(STARVE_LIMIT));
  assign fifo_count_o = w_count;
  assign rf_we_o      = r_we;
  assign rf_rd_o      = r_out.rd;
  assign rf_data_o    = r_out.data;
  assign rf_pos_o     = r_out.pos;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed self-checking bench for rf_wb_arbiter (DEPTH=4,
//            STARVE_LIMIT=8). Inputs change 1 time unit after posedge and
//            outputs are sampled there too, away from the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        cpu_we_i;
  logic [4:0]  cpu_rd_i;
  logic [31:0] cpu_data_i;
  logic [3:0]  cpu_pos_i;
  logic        cgra_valid_i;
  logic        cgra_ready_o;
  logic [4:0]  cgra_rd_i;
  logic [31:0] cgra_data_i;
  logic [3:0]  cgra_pos_i;
  logic        flush_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic        hazard_o;
  logic        starve_o;
  logic [2:0]  fifo_count_o;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic [3:0]  rf_pos_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  rf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .reset(reset),
    .cpu_we_i(cpu_we_i), .cpu_rd_i(cpu_rd_i), .cpu_data_i(cpu_data_i), .cpu_pos_i(cpu_pos_i),
    .cgra_valid_i(cgra_valid_i), .cgra_ready_o(cgra_ready_o), .cgra_rd_i(cgra_rd_i),
    .cgra_data_i(cgra_data_i), .cgra_pos_i(cgra_pos_i), .flush_i(flush_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .hazard_o(hazard_o), .starve_o(starve_o),
    .fifo_count_o(fifo_count_o), .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o),
    .rf_data_o(rf_data_o), .rf_pos_o(rf_pos_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we_i = 0; cpu_rd_i = 0; cpu_data_i = 0; cpu_pos_i = 0;
    cgra_valid_i = 0; cgra_rd_i = 0; cgra_data_i = 0; cgra_pos_i = 0;
    flush_i = 0; rs_addr_i = 0; rt_addr_i = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    n_vec++;
    if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_data_o !== 32'd0 || rf_pos_o !== 4'd0) begin
      n_err++; $display("FAIL reset_rf got we=%0b rd=%0d data=%h pos=%h exp all 0", rf_we_o, rf_rd_o, rf_data_o, rf_pos_o);
    end
    n_vec++;
    if (fifo_count_o !== 3'd0 || cgra_ready_o !== 1'b1 || starve_o !== 1'b0 || hazard_o !== 1'b0) begin
      n_err++; $display("FAIL reset_state got cnt=%0d rdy=%0b starve=%0b haz=%0b exp 0/1/0/0", fifo_count_o, cgra_ready_o, starve_o, hazard_o);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_only();
    cpu_we_i = 1; cpu_rd_i = 5; cpu_data_i = 32'hDEADBEEF; cpu_pos_i = 4'h3;
    tick();
    n_vec++;
    if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd5 || rf_data_o !== 32'hDEADBEEF || rf_pos_o !== 4'h3) begin
      n_err++; $display("FAIL cpu_write got we=%0b rd=%0d data=%h pos=%h exp 1/5/deadbeef/3", rf_we_o, rf_rd_o, rf_data_o, rf_pos_o);
    end
    cpu_rd_i = 0; cpu_data_i = 32'h12345678; cpu_pos_i = 4'h9;
    tick();
    n_vec++;
    if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd5 || rf_data_o !== 32'hDEADBEEF || rf_pos_o !== 4'h3) begin
      n_err++; $display("FAIL cpu_x0 got we=%0b rd=%0d data=%h pos=%h exp 0/5/deadbeef/3", rf_we_o, rf_rd_o, rf_data_o, rf_pos_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_cgra_only();
    cgra_valid_i = 1; cgra_rd_i = 7; cgra_data_i = 32'hA7; cgra_pos_i = 4'h1;
    tick();
    n_vec++;
    if (rf_we_o !== 1'b0 || fifo_count_o !== 3'd1) begin
      n_err++; $display("FAIL cgra_hs1 got we=%0b cnt=%0d exp 0/1", rf_we_o, fifo_count_o);
    end
    cgra_rd_i = 8; cgra_data_i = 32'hA8; cgra_pos_i = 4'h2;
    tick();
    n_vec++;
    if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd7 || rf_data_o !== 32'hA7 || rf_pos_o !== 4'h1 || fifo_count_o !== 3'd1) begin
      n_err++; $display("FAIL cgra_first got we=%0b rd=%0d data=%h pos=%h cnt=%0d exp 1/7/a7/1/1", rf_we_o, rf_rd_o, rf_data_o, rf_pos_o, fifo_count_o);
    end
    cgra_valid_i = 0;
    tick();
    n_vec++;
    if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd8 || rf_data_o !== 32'hA8 || rf_pos_o !== 4'h2 || fifo_count_o !== 3'd0) begin
      n_err++; $display("FAIL cgra_second got we=%0b rd=%0d data=%h pos=%h cnt=%0d exp 1/8/a8/2/0", rf_we_o, rf_rd_o, rf_data_o, rf_pos_o, fifo_count_o);
    end
    tick();
    n_vec++;
    if (rf_we_o !== 1'b0) begin
      n_err++; $display("FAIL cgra_idle got we=%0b exp 0", rf_we_o);
    end
  endtask

  task automatic test_priority_full();
    cpu_we_i = 1; cgra_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      cpu_rd_i = 5'(1 + i); cpu_data_i = 32'hC0000000 + i;
      cgra_rd_i = 5'(10 + i); cgra_data_i = 32'hC0DE0000 + i; cgra_pos_i = 4'(i);
      tick();
      n_vec++;
      if (rf_we_o !== 1'b1 || rf_rd_o !== 5'(1 + i) || rf_data_o !== 32'hC0000000 + i) begin
        n_err++; $display("FAIL prio_cpu%0d got we=%0b rd=%0d data=%h exp 1/%0d/%h", i, rf_we_o, rf_rd_o, rf_data_o, 1 + i, 32'hC0000000 + i);
      end
    end
    n_vec++;
    if (fifo_count_o !== 3'd4 || cgra_ready_o !== 1'b0) begin
      n_err++; $display("FAIL full got cnt=%0d rdy=%0b exp 4/0", fifo_count_o, cgra_ready_o);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (rf_we_o !== 1'b1 || rf_rd_o !== 5'(10 + i) || rf_data_o !== 32'hC0DE0000 + i || rf_pos_o !== 4'(i)) begin
        n_err++; $display("FAIL drain%0d got we=%0b rd=%0d data=%h pos=%h exp 1/%0d/%h/%0d", i, rf_we_o, rf_rd_o, rf_data_o, rf_pos_o, 10 + i, 32'hC0DE0000 + i, i);
      end
    end
    tick();
    n_vec++;
    if (rf_we_o !== 1'b0 || fifo_count_o !== 3'd0 || cgra_ready_o !== 1'b1) begin
      n_err++; $display("FAIL drained got we=%0b cnt=%0d rdy=%0b exp 0/0/1", rf_we_o, fifo_count_o, cgra_ready_o);
    end
  endtask

  task automatic test_starvation();
    cpu_we_i = 1; cpu_rd_i = 2; cpu_data_i = 32'h2;
    cgra_valid_i = 1; cgra_rd_i = 20; cgra_data_i = 32'h20; cgra_pos_i = 4'h5;
    tick();
    cgra_valid_i = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 7) begin
        n_vec++;
        if (starve_o !== 1'b0) begin
          n_err++; $display("FAIL starve_early got %0b exp 0", starve_o);
        end
      end
      if (i == 8 || i == 9) begin
        n_vec++;
        if (starve_o !== 1'b1 || fifo_count_o !== 3'd1) begin
          n_err++; $display("FAIL starve_set%0d got starve=%0b cnt=%0d exp 1/1", i, starve_o, fifo_count_o);
        end
      end
    end
    cpu_we_i = 0;
    tick();
    n_vec++;
    if (starve_o !== 1'b0 || rf_we_o !== 1'b1 || rf_rd_o !== 5'd20 || fifo_count_o !== 3'd0) begin
      n_err++; $display("FAIL starve_clear got starve=%0b we=%0b rd=%0d cnt=%0d exp 0/1/20/0", starve_o, rf_we_o, rf_rd_o, fifo_count_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hazard();
    cpu_we_i = 1; cpu_rd_i = 3;
    cgra_valid_i = 1; cgra_rd_i = 9; cgra_data_i = 32'h99;
    tick();
    cgra_valid_i = 0;
    rs_addr_i = 9; rt_addr_i = 0; #1;
    n_vec++;
    if (hazard_o !== 1'b1) begin
      n_err++; $display("FAIL hazard_rs got %0b exp 1", hazard_o);
    end
    rs_addr_i = 0; rt_addr_i = 10; #1;
    n_vec++;
    if (hazard_o !== 1'b0) begin
      n_err++; $display("FAIL hazard_none got %0b exp 0", hazard_o);
    end
    rt_addr_i = 9; #1;
    n_vec++;
    if (hazard_o !== 1'b1) begin
      n_err++; $display("FAIL hazard_rt got %0b exp 1", hazard_o);
    end
    cpu_we_i = 0; #1;
    n_vec++;
    if (hazard_o !== 1'b1) begin
      n_err++; $display("FAIL hazard_popping got %0b exp 1", hazard_o);
    end
    tick();
    n_vec++;
    if (hazard_o !== 1'b0 || rf_rd_o !== 5'd9 || fifo_count_o !== 3'd0) begin
      n_err++; $display("FAIL hazard_after got haz=%0b rd=%0d cnt=%0d exp 0/9/0", hazard_o, rf_rd_o, fifo_count_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    cpu_we_i = 1; cpu_rd_i = 4; cgra_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      cgra_rd_i = 5'(21 + i); cgra_data_i = 32'h21 + i;
      tick();
    end
    n_vec++;
    if (fifo_count_o !== 3'd3) begin
      n_err++; $display("FAIL flush_pre got cnt=%0d exp 3", fifo_count_o);
    end
    flush_i = 1; cgra_rd_i = 24; cpu_rd_i = 3; cpu_data_i = 32'hF;
    tick();
    n_vec++;
    if (fifo_count_o !== 3'd0 || rf_we_o !== 1'b1 || rf_rd_o !== 5'd3 || rf_data_o !== 32'hF || starve_o !== 1'b0) begin
      n_err++; $display("FAIL flush got cnt=%0d we=%0b rd=%0d data=%h starve=%0b exp 0/1/3/f/0", fifo_count_o, rf_we_o, rf_rd_o, rf_data_o, starve_o);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (rf_we_o !== 1'b0 || fifo_count_o !== 3'd0) begin
        n_err++; $display("FAIL flush_after%0d got we=%0b cnt=%0d exp 0/0", i, rf_we_o, fifo_count_o);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    cpu_we_i = 1; cpu_rd_i = 6; cgra_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      cgra_rd_i = 5'(25 + i); cgra_data_i = 32'h25 + i;
      tick();
    end
    idle_inputs();
    tick();
    n_vec++;
    if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd25 || fifo_count_o !== 3'd2) begin
      n_err++; $display("FAIL pre_reset got we=%0b rd=%0d cnt=%0d exp 1/25/2", rf_we_o, rf_rd_o, fifo_count_o);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd0 || fifo_count_o !== 3'd0 || cgra_ready_o !== 1'b1) begin
      n_err++; $display("FAIL async_reset got we=%0b rd=%0d cnt=%0d rdy=%0b exp 0/0/0/1", rf_we_o, rf_rd_o, fifo_count_o, cgra_ready_o);
    end
    #1;
    reset = 1'b0;
    tick();
    n_vec++;
    if (rf_we_o !== 1'b0 || fifo_count_o !== 3'd0) begin
      n_err++; $display("FAIL post_reset got we=%0b cnt=%0d exp 0/0", rf_we_o, fifo_count_o);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_only();
    test_cgra_only();
    test_priority_full();
    test_starvation();
    test_hazard();
    test_flush();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates the register file's single write port between two writers: the CPU pipeline writeback and the CGRA result return path. CPU writes have absolute priority and are never back-pressured. CGRA results are buffered in a small FIFO and drained on cycles the CPU does not write. The block also supplies a read-after-write hazard flag, so the CPU can stall on registers with queued CGRA writes, and a starvation flag that requests a pipeline bubble.

Parameters:
DEPTH, 4, CGRA result FIFO entries (power of two, ≥2)
STARVE_LIMIT, 8, consecutive CPU-won cycles with a non-empty FIFO before starve_o asserts

Ports:
clk_i  in  1  clock, posedge
reset  in  1  asynchronous, active-high reset
cpu_we_i  in  1  CPU writeback valid
cpu_rd_i  in  5  CPU destination register
cpu_data_i  in  32  CPU write data
cpu_pos_i  in  4  CPU is_pos tag
cgra_valid_i  in  1  CGRA result valid
cgra_ready_o  out  1  FIFO can accept
cgra_rd_i  in  5  CGRA destination register
cgra_data_i  in  32  CGRA result data
cgra_pos_i  in  4  CGRA is_pos tag
flush_i  in  1  synchronous discard of queued CGRA results
rs_addr_i  in  5  decode-stage source address 1
rt_addr_i  in  5  decode-stage source address 2
hazard_o  out  1  source matches a queued CGRA write
starve_o  out  1  request CPU bubble
fifo_count_o  out  $clog2(DEPTH)+1  occupancy
rf_we_o  out  1  register file RegWrite
rf_rd_o  out  5  register file RDaddr
rf_data_o  out  32  register file RDdata
rf_pos_o  out  4  register file is_pos

Behaviour:
- Reset:
  - Reset is asynchronous and active-high.
  - The FIFO is emptied and the starve counter is cleared.
  - rf_we_o, rf_rd_o, rf_data_o, rf_pos_o, starve_o and hazard_o are all 0; fifo_count_o is 0; cgra_ready_o is 1.
  - Reset asserted mid-operation drops all queued and in-flight writes.
- Output stage:
  - rf_* outputs are registered on posedge.
  - The register file samples them on the following negedge.
- CGRA handshake:
  - A transfer occurs when cgra_valid_i and cgra_ready_o are both high.
  - cgra_ready_o = (count < DEPTH). It depends only on state, never on cgra_valid_i.
- x0 filtering:
  - A CPU write with rd=0 is ignored (no grant).
  - A CGRA transfer with rd=0 is accepted and discarded, so count is unchanged.
- Grant priority, evaluated each cycle:
  1. If cpu_we_i and cpu_rd_i≠0: register the CPU write (GNT_CPU).
  2. Else if the FIFO is non-empty: pop the head and register it (GNT_CGRA).
  3. Else: rf_we_o=0 next cycle. rf_rd_o, rf_data_o and rf_pos_o hold their previous values.
- Latency:
  - CPU: 1 cycle from cpu_we_i to rf_we_o.
  - CGRA: minimum 2 cycles from handshake to rf_we_o. There is no FIFO bypass; every CGRA result passes through the FIFO.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - A push on a full FIFO is impossible because ready is low.
- Ordering:
  - CGRA results are written in arrival order.
  - CPU and CGRA writes to the same rd commit in grant order. Correctness relies on the CPU honouring hazard_o.
- hazard_o (combinational):
  - Asserts when any valid FIFO entry has rd equal to a non-zero rs_addr_i or rt_addr_i.
  - Entries popped this cycle still count as queued.
- Starve counter:
  - Increments on each GNT_CPU cycle while the FIFO is non-empty.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - starve_o = (counter == STARVE_LIMIT), registered.
  - The block never overrides CPU priority. The bubble is the pipeline's responsibility.
- flush_i:
  - Clears the FIFO and the starve counter at the next posedge.
  - A CGRA transfer in the same cycle is discarded.
  - A CPU write in the same cycle is still granted.
  - An already-registered rf_* write still completes.
- fifo_count_o: reflects registered occupancy.

Decomposition:
- Package rf_wb_pkg:
  - RF_ADDR_W=5, RF_DATA_W=32, POS_W=4.
  - Grant enum GNT_NONE/GNT_CPU/GNT_CGRA.
  - wb_entry_t struct {rd, data, pos}.
- Sub-module wb_fifo:
  - Synchronous FIFO with async reset, parameterised DEPTH.
  - Provides push/pop/flush, a count output, and an entry-valid vector plus rd array for hazard compare.
- The top level holds the grant logic, starve counter, output register and hazard compare.

Test Plan:
1. CPU only: cpu_we_i=1, rd=5, data=32'hDEADBEEF, pos=4'h3 → the next cycle shows rf_we_o=1, rf_rd_o=5, rf_data_o=DEADBEEF, rf_pos_o=3. With rd=0, rf_we_o stays 0.
2. CGRA only: push rd=7 then rd=8 on consecutive cycles with the CPU idle → rf_we_o is high for rd 7 then rd 8, with the first write 2 cycles after the first handshake. fifo_count_o peaks at 1.
3. Priority/full: CPU writes every cycle while the CGRA pushes 5 entries with DEPTH=4 → cgra_ready_o drops after 4, count=4. Entries drain in order once cpu_we_i deasserts.
4. Starvation: FIFO holds 1 entry and the CPU writes for 8 consecutive cycles → starve_o=1 on the cycle after the 8th CPU-won cycle. After a 1-cycle CPU bubble, the entry pops and starve_o returns to 0.
5. Hazard: FIFO holds rd=9, with rs_addr_i=9 → hazard_o=1. With rs_addr_i=0 and rt_addr_i=10 → hazard_o=0.
6. Flush/reset: 3 queued entries plus a concurrent push, then assert flush_i → count=0 and no CGRA writes appear afterwards. Asserting reset mid-drain immediately zeroes rf_we_o and count.
